// File: rtl/risc_pkg.sv
// Shared fetch-stage constants and state encoding; no logic, no latency.
// Fetch FSM: RESET -> FETCH <-> VALID, DRAIN absorbs a wrong-path response after a redirect.
package risc_pkg;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 7;
    localparam int OPCODE_LSB = 25;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_VALID,
        ST_DRAIN
    } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// One-entry instr/pc holding register for prefetched words (IFETCH_PREFETCH_EN only); load visible next cycle.
// No backpressure of its own: the fetch stage stops requesting while vld=1; clear wins over load/pop.
`ifdef IFETCH_PREFETCH_EN
module fetch_buf
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [INSTR_W-1:0]  ld_instr,
    input  logic [ADDR_W-1:0]   ld_pc,
    input  logic                pop,
    input  logic                clear,
    output logic                vld,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   pc
);
    logic                vld_q, vld_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

    always_comb begin
        vld_d   = vld_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d   = 1'b1;
            instr_d = ld_instr;
            pc_d    = ld_pc;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign vld   = vld_q;
    assign instr = instr_q;
    assign pc    = pc_q;
endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch: PC owner, imem req/ack master, registered valid/ready output; if_valid 1 cycle after ack.
// Holds output while if_ready=0; redirects drain any outstanding request; IFETCH_PREFETCH_EN adds a 1-entry prefetch.
module instr_fetch
    import risc_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [INSTR_W-1:0]   if_instr,
    output logic [OPCODE_W-1:0]  if_opcode,
    output logic [ADDR_W-1:0]    if_pc,
    input  logic                 br_taken,
    input  logic                 br_reg,
    input  logic [ADDR_W-1:0]    br_rs,
    input  logic [ADDR_W-1:0]    br_label
);
    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   drain_addr_q, drain_addr_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;

    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   br_target;
    logic                handshake;
    logic                req_in_valid;

`ifdef IFETCH_PREFETCH_EN
    logic                buf_vld, buf_load, buf_pop, buf_clear;
    logic [INSTR_W-1:0]  buf_instr;
    logic [ADDR_W-1:0]   buf_pc;

    fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .ld_instr (imem_rdata),
        .ld_pc    (pc_q),
        .pop      (buf_pop),
        .clear    (buf_clear),
        .vld      (buf_vld),
        .instr    (buf_instr),
        .pc       (buf_pc)
    );
    assign req_in_valid = (state_q == ST_VALID) && !buf_vld;
`else
    assign req_in_valid = 1'b0;
`endif

    assign pc_inc    = pc_q + ADDR_W'(PC_INC);
    assign br_target = (br_reg ? br_rs : br_label) & ~ADDR_W'(3);
    assign if_valid  = (state_q == ST_VALID);
    assign handshake = if_valid && if_ready;
    assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN) || req_in_valid;
    assign imem_addr = (state_q == ST_RESET) ? RESET_PC :
                       (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        ipc_d        = ipc_q;
`ifdef IFETCH_PREFETCH_EN
        buf_load     = 1'b0;
        buf_pop      = 1'b0;
        buf_clear    = 1'b0;
`endif
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_inc;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
`ifdef IFETCH_PREFETCH_EN
                // A buffered word or a same-cycle ack refills the output with no bubble.
                if (handshake) begin
                    if (buf_vld) begin
                        instr_d = buf_instr;
                        ipc_d   = buf_pc;
                        buf_pop = 1'b1;
                    end else if (imem_ack) begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (req_in_valid && imem_ack) begin
                    buf_load = 1'b1;
                    pc_d     = pc_inc;
                end
`else
                if (handshake) begin
                    state_d = ST_FETCH;
                end
`endif
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Redirect overrides any handshake or ack above; a still-open request must be drained first.
        if (br_taken && (state_q != ST_RESET)) begin
            pc_d    = br_target;
            instr_d = instr_q;
            ipc_d   = ipc_q;
`ifdef IFETCH_PREFETCH_EN
            buf_load  = 1'b0;
            buf_pop   = 1'b0;
            buf_clear = 1'b1;
`endif
            if (imem_req && !imem_ack) begin
                state_d      = ST_DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= '0;
            ipc_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
        end
    end

    assign if_instr  = instr_q;
    assign if_opcode = instr_q[OPCODE_LSB +: OPCODE_W];
    assign if_pc     = ipc_q;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-issue RISC core. Owns the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents them with valid/ready to the decode/control stage, which consumes the 7-bit operation field. Accepts taken-branch redirects (label or register target) from the branch resolution logic and flushes wrong-path fetches.

## Interface
- ADDR_W, 32, PC/byte-address width
- RESET_PC, 0, PC value after reset (bits [1:0] must be 0)
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
- imem_ack  in  1  memory response, rdata valid same cycle
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  instruction valid to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  registered instruction
- if_opcode  out  7  if_instr[31:25], operation field for control
- if_pc  out  ADDR_W  address of if_instr
- br_taken  in  1  single-cycle redirect strobe
- br_reg  in  1  1: target = br_rs (jump register), 0: target = br_label
- br_rs  in  ADDR_W  register target
- br_label  in  ADDR_W  label target

## Operation
- States: RESET, FETCH, VALID, DRAIN.
- RESET: entered on rst_n=0; imem_req=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC; leaves to FETCH on first edge after rst_n deasserts.
- FETCH: imem_req=1, imem_addr=pc. On edge with imem_ack=1: if_instr<=imem_rdata, if_pc<=pc, pc<=pc+4, go VALID.
- VALID: if_valid=1. On edge with if_valid&if_ready: if_valid drops, go FETCH (base build).
- Redirect (br_taken=1 at an edge, any state except RESET): target = br_reg ? br_rs : br_label, bits [1:0] forced 0; pc<=target; if_valid<=0; prefetch buffer cleared. Redirect wins over a simultaneous if_ready handshake (instruction counts as not accepted) and over a simultaneous ack (data discarded).
- If a request is outstanding (FETCH, imem_req=1, no ack at that edge) when redirect arrives: go DRAIN; hold imem_req=1 and old imem_addr until ack, discard data, then FETCH at target. A second redirect during DRAIN overwrites the saved target.
- PC arithmetic modulo 2^ADDR_W; pc+4 wraps to 0 silently.
- Reset mid-fetch: outputs return to reset values immediately; outstanding memory response is ignored.

## Timing
- Zero-wait memory (ack in request cycle): base build delivers one instruction per 2 cycles with if_ready held high.
- Latency request-to-if_valid: 1 cycle after ack edge.
- if_valid, if_instr, if_pc, if_opcode stable while if_valid=1 and no handshake/redirect.
- Redirect to first target request: next cycle (no outstanding fetch) or cycle after drain ack.

## Configuration
- IFETCH_PREFETCH_EN defined: in VALID, imem_req also issues for pc; acked word stored in one-entry prefetch buffer (instr+pc). On handshake, buffer (or same-cycle ack data) loads output register with no bubble: 1 instruction/cycle with zero-wait memory and if_ready=1. Request stalls while buffer full. Redirect clears buffer; outstanding prefetch goes through DRAIN.
- Not defined: no buffer, no request in VALID; behaviour as above.

## Structure
- Shared package risc_pkg: INSTR_W=32, OPCODE_W=7, OPCODE_LSB=25, fetch state enum, PC_INC=4.
- One sub-module natural only with prefetch: fetch_buf (one-entry instr/pc buffer, valid flag, clear input). Otherwise flat.

## Test plan
- Reset release, imem_ack tied 1, if_ready=1, rdata=addr-derived -> first request at RESET_PC one cycle after release; if_pc sequence 0,4,8 every 2 cycles (every cycle with IFETCH_PREFETCH_EN).
- if_ready=0 for 5 cycles at pc 0x8 -> if_instr/if_pc held constant, no extra request (base), pc advances only after handshake.
- br_taken with br_reg=0, br_label=0x40 while VALID -> if_valid drops next edge, next request addr 0x40; br_reg=1, br_rs=0x103 -> request addr 0x100.
- br_taken while request outstanding with ack delayed 3 cycles -> imem_addr held old value through ack, data never appears on if_instr, then request at target.
- br_taken coincident with if_valid&if_ready and with imem_ack -> both discarded, next if_pc equals target.
- PC at 0xFFFFFFFC fetched -> next if_pc 0x0; rst_n pulsed low mid-wait -> all outputs zero asynchronously, restart at RESET_PC.
